// File: rtl/sobel_window_gen.sv
// Line-buffer 3x3 window generator: turns a raster pixel stream into packed
// neighbourhood windows for interior pixels only, with strobe/busy handshakes.
module sobel_window_gen #(
    parameter int IMG_WIDTH = 640,
    parameter int DATAWIDTH = 8,
    parameter int PIXEL     = 3,
    parameter int ROW_LOOP  = 3
) (
    input  logic                                clk,
    input  logic                                ARESETN,
    input  logic [DATAWIDTH-1:0]                i_pixel,
    input  logic                                i_pix_strobe,
    input  logic                                in_tlast,
    output logic                                o_busy,
    output logic [DATAWIDTH*PIXEL*ROW_LOOP-1:0] packed_out,
    output logic                                o_strobe,
    output logic                                out_tlast,
    input  logic                                i_busy
);

    localparam int              COL_W    = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    logic [COL_W-1:0] col;
    logic [1:0]       rows;

    // Packed so that the flattened vector matches the packed_out field layout.
    logic [PIXEL-1:0][ROW_LOOP-1:0][DATAWIDTH-1:0] win;
    logic [PIXEL-1:0][ROW_LOOP-1:0][DATAWIDTH-1:0] win_nxt;

    logic [DATAWIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATAWIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATAWIDTH-1:0] lb0_rd;
    logic [DATAWIDTH-1:0] lb1_rd;

    logic accept;
    logic win_valid;
    logic drain;

    assign o_busy    = !ARESETN || (o_strobe && i_busy);
    assign accept    = i_pix_strobe && !o_busy;
    assign drain     = o_strobe && !i_busy;
    assign win_valid = (rows == 2'd2) && (col >= COL_TWO);

    // Asynchronous read gives the old line contents before this cycle's write.
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    always_comb begin
        win_nxt = win;
        for (int i = 0; i < PIXEL; i++) begin
            for (int j = 0; j < ROW_LOOP - 1; j++) begin
                win_nxt[i][j] = win[i][j+1];
            end
        end
        win_nxt[0][ROW_LOOP-1] = lb1_rd;
        win_nxt[1][ROW_LOOP-1] = lb0_rd;
        win_nxt[2][ROW_LOOP-1] = i_pixel;
    end

    // Line memories hold stale data across frames; rows gating keeps it out of windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge ARESETN) begin
        if (!ARESETN) begin
            col        <= '0;
            rows       <= '0;
            win        <= '0;
            packed_out <= '0;
            o_strobe   <= 1'b0;
            out_tlast  <= 1'b0;
        end else begin
            if (accept) begin
                win <= win_nxt;
                if (in_tlast) begin
                    col  <= '0;
                    rows <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    if (rows != 2'd2) begin
                        rows <= rows + 2'd1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (accept && win_valid) begin
                packed_out <= win_nxt;
                o_strobe   <= 1'b1;
                out_tlast  <= in_tlast;
            end else if (drain) begin
                o_strobe  <= 1'b0;
                out_tlast <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: table of frame cases, directed stall/reset
// sequences and random handshake frames, all checked against a pixel-grid model.
module tb_sobel_window_gen;

    localparam int W  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] i_pixel = '0;
    logic          i_pix_strobe = 1'b0;
    logic          in_tlast = 1'b0;
    logic          o_busy;
    logic [71:0]   packed_out;
    logic          o_strobe;
    logic          out_tlast;
    logic          i_busy = 1'b0;

    sobel_window_gen #(.IMG_WIDTH(W), .DATAWIDTH(DW), .PIXEL(3), .ROW_LOOP(3)) dut (
        .clk          (clk),
        .ARESETN      (ARESETN),
        .i_pixel      (i_pixel),
        .i_pix_strobe (i_pix_strobe),
        .in_tlast     (in_tlast),
        .o_busy       (o_busy),
        .packed_out   (packed_out),
        .o_strobe     (o_strobe),
        .out_tlast    (out_tlast),
        .i_busy       (i_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        logic        tlast;
    } exp_t;

    typedef struct {
        int base;
        int npix;
        int exp_win;
        int exp_tlast;
    } frame_case_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    logic [71:0] seen[$];
    int          win_cnt   = 0;
    int          tlast_cnt = 0;
    int          busy_mode = 0;

    logic [DW-1:0] img [16][W];
    int            mr = 0;
    int            mc = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [71:0] pack9(input int p0, input int p1, input int p2,
                                          input int p3, input int p4, input int p5,
                                          input int p6, input int p7, input int p8);
        return {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0],
                p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endfunction

    // Reference: keep the whole frame as a grid and cut the 3x3 neighbourhood.
    task automatic model_accept(input logic [DW-1:0] p, input logic last);
        exp_t e;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[DW*(3*i+j) +: DW] = img[mr-2+i][mc-2+j];
            e.tlast = last;
            sb.push_back(e);
        end
        if (last) begin
            mr = 0;
            mc = 0;
        end else if (mc == W - 1) begin
            mc = 0;
            if (mr < 15) mr++;
        end else begin
            mc++;
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        sb.delete();
    endtask

    always @(posedge clk) begin
        #2;
        case (busy_mode)
            0:       i_busy = 1'b0;
            1:       i_busy = 1'b1;
            default: i_busy = ($urandom_range(0, 2) == 0);
        endcase
    end

    logic        stall_prev = 1'b0;
    logic [71:0] hold_p;
    logic        hold_t;

    always @(negedge clk) begin
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (o_strobe && stall_prev) begin
                check("stall_packed", packed_out, hold_p);
                check("stall_tlast", {71'd0, out_tlast}, {71'd0, hold_t});
            end
            if (o_strobe && i_busy) begin
                stall_prev = 1'b1;
                hold_p     = packed_out;
                hold_t     = out_tlast;
            end else begin
                stall_prev = 1'b0;
            end
            if (o_strobe && !i_busy) begin
                exp_t e;
                if (sb.size() == 0) begin
                    check("unexpected_window", 72'd1, 72'd0);
                end else begin
                    e = sb.pop_front();
                    check("window", packed_out, e.win);
                    check("tlast", {71'd0, out_tlast}, {71'd0, e.tlast});
                end
                win_cnt++;
                if (out_tlast) tlast_cnt++;
                seen.push_back(packed_out);
            end
        end
    end

    task automatic send_pixel(input logic [DW-1:0] p, input logic last, input bit gaps);
        bit done = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            i_pix_strobe = 1'b0;
            @(posedge clk);
            #1;
        end
        i_pixel      = p;
        in_tlast     = last;
        i_pix_strobe = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!o_busy) begin
                model_accept(p, last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_pix_strobe = 1'b0;
        in_tlast     = 1'b0;
        if (!done) check("accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic run_frame(input int base, input int npix, input bit gaps);
        for (int k = 0; k < npix; k++) send_pixel(8'(base + k), k == npix - 1, gaps);
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((sb.size() != 0 || o_strobe) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain", {71'd0, (sb.size() != 0 || o_strobe)}, 72'd0);
    endtask

    frame_case_t cases[6];

    initial begin
        int w0, t0, s0;

        cases[0] = '{0,   16, 4, 1};
        cases[1] = '{100, 16, 4, 1};
        cases[2] = '{0,   10, 0, 0};
        cases[3] = '{0,   16, 4, 1};
        cases[4] = '{50,  24, 8, 1};
        cases[5] = '{20,  15, 3, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {71'd0, o_busy}, 72'd1);
        check("rst_strobe", {71'd0, o_strobe}, 72'd0);
        check("rst_tlast", {71'd0, out_tlast}, 72'd0);
        check("rst_packed", packed_out, 72'd0);
        ARESETN = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            w0 = win_cnt;
            t0 = tlast_cnt;
            s0 = seen.size();
            run_frame(cases[k].base, cases[k].npix, 1'b0);
            wait_drain();
            check("case_windows", 72'(win_cnt - w0), 72'(cases[k].exp_win));
            check("case_tlasts", 72'(tlast_cnt - t0), 72'(cases[k].exp_tlast));
            if (k == 0) begin
                check("first_window", seen[s0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
                check("last_window", seen[s0+3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
            end
            if (k == 1) check("frame2_first", seen[s0], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        end

        // Downstream stall while the first window of the frame is pending.
        w0 = win_cnt;
        t0 = tlast_cnt;
        for (int k = 0; k < 10; k++) send_pixel(8'(k), 1'b0, 1'b0);
        busy_mode = 1;
        send_pixel(8'd10, 1'b0, 1'b0);
        i_pixel      = 8'd11;
        in_tlast     = 1'b0;
        i_pix_strobe = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_obusy", {71'd0, o_busy}, 72'd1);
            check("stall_first", packed_out, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
            @(posedge clk);
            #1;
        end
        i_pix_strobe = 1'b0;
        busy_mode    = 0;
        for (int k = 11; k < 16; k++) send_pixel(8'(k), k == 15, 1'b0);
        wait_drain();
        check("stall_windows", 72'(win_cnt - w0), 72'd4);
        check("stall_tlasts", 72'(tlast_cnt - t0), 72'd1);

        // Reset in the middle of a frame.
        for (int k = 0; k < 10; k++) send_pixel(8'(k), 1'b0, 1'b0);
        ARESETN = 1'b0;
        #1;
        check("midrst_busy", {71'd0, o_busy}, 72'd1);
        check("midrst_strobe", {71'd0, o_strobe}, 72'd0);
        check("midrst_tlast", {71'd0, out_tlast}, 72'd0);
        check("midrst_packed", packed_out, 72'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        ARESETN = 1'b1;
        w0 = win_cnt;
        t0 = tlast_cnt;
        s0 = seen.size();
        run_frame(0, 16, 1'b0);
        wait_drain();
        check("postrst_windows", 72'(win_cnt - w0), 72'd4);
        check("postrst_tlasts", 72'(tlast_cnt - t0), 72'd1);
        check("postrst_first", seen[s0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));

        // Random pixels, input gaps and downstream stalls over 4x6 frames.
        busy_mode = 2;
        w0 = win_cnt;
        t0 = tlast_cnt;
        for (int f = 0; f < 100; f++)
            for (int k = 0; k < 24; k++) send_pixel(8'($urandom), k == 23, 1'b1);
        busy_mode = 0;
        wait_drain();
        check("rand_windows", 72'(win_cnt - w0), 72'd800);
        check("rand_tlasts", 72'(tlast_cnt - t0), 72'd100);

        check("sb_empty", 72'(sb.size()), 72'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Line-buffer window generator that turns a raster pixel stream into 3x3 neighbourhood windows for the Sobel datapath. It sits upstream of the 3x3 window skid buffer and acts as the transmitter on that strobe/busy window interface. It accepts one pixel per transfer from the pixel source, keeps the two previous image lines in on-chip line memories, and emits one packed 3x3 window per fully-interior pixel, with no border padding.

## Interface
- IMG_WIDTH, 640, pixels per image line; must be ≥ 3.
- DATAWIDTH, 8, bits per pixel.
- PIXEL, 3, window rows; fixed at 3.
- ROW_LOOP, 3, window columns; fixed at 3.
- clk  in  1  single clock; all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk externally.
- i_pixel  in  DATAWIDTH  input pixel.
- i_pix_strobe  in  1  input pixel valid.
- in_tlast  in  1  last pixel of the frame; qualified by i_pix_strobe.
- o_busy  out  1  upstream stall; high means the pixel is not accepted this cycle.
- packed_out  out  DATAWIDTH*PIXEL*ROW_LOOP  window. Byte field [DATAWIDTH*(ROW_LOOP*i+j) +: DATAWIDTH] is row i (0 = two lines ago/top, 2 = current line) and column j (0 = oldest/left, 2 = newest/right).
- o_strobe  out  1  window valid; held until taken.
- out_tlast  out  1  last window of the frame; qualified by o_strobe.
- i_busy  in  1  downstream stall.

## Operation
- Input transfer occurs when i_pix_strobe && !o_busy.
- Output transfer occurs when o_strobe && !i_busy.
- o_busy = !ARESETN || (o_strobe && i_busy). This is combinational, so a pixel is accepted in the same cycle that a pending window drains.
- State:
  - col counter, 0..IMG_WIDTH-1.
  - row counter rows, 0..2 (saturating).
  - 3x3 window shift registers win[i][j].
  - two line memories, lb0 (previous line) and lb1 (two lines ago), IMG_WIDTH x DATAWIDTH each.
  - Line memories are not reset; their contents are gated by rows.
- On each accepted pixel p at column col:
  - Shift win[i][0] ← win[i][1] and win[i][1] ← win[i][2] for all i.
  - Load win[0][2] ← lb1[col], win[1][2] ← lb0[col], win[2][2] ← p.
  - Write lb1[col] ← lb0[col] and lb0[col] ← p.
- Window valid condition: rows == 2 && col ≥ 2, evaluated before the counter update.
  - If valid, load packed_out from the post-shift window, set o_strobe = 1, and set out_tlast = in_tlast.
- Counter update:
  - If in_tlast, set col = 0 and rows = 0, starting a new frame.
  - Else if col == IMG_WIDTH-1, set col = 0 and rows = min(rows+1, 2).
  - Else col = col+1.
- Frame of H full lines produces (IMG_WIDTH-2)*(H-2) windows. out_tlast rides the window of the final pixel.
- Truncated frame (in_tlast at any position):
  - Counters reset.
  - If that pixel completed a valid window, that window carries out_tlast. Otherwise no out_tlast is generated for the frame.
- When an output transfer happens with no new valid window in the same cycle, o_strobe ← 0 and out_tlast ← 0.
- A window is never dropped and never duplicated. Input is blocked only while the output register is occupied and stalled.

## Timing
- Reset values: o_strobe 0, out_tlast 0, packed_out 0, col 0, rows 0, win all 0. o_busy is 1 while ARESETN is low.
- Latency: an accepted pixel completing a window produces o_strobe high on the next rising edge.
- Throughput: one pixel per cycle while i_busy stays low.
- Line memories: 1 read and 1 write per accepted pixel at the same address.
  - Read-before-write ordering: read old data, write new.
  - Either async-read distributed RAM or a registered read with win update aligned.
  - Either way, externally visible latency stays 1 cycle.
- Reset asserted mid-frame: all state above clears immediately. Any partial frame is discarded. The first pixel after reset is treated as row 0, column 0.
- i_busy may toggle arbitrarily. While o_strobe && i_busy, packed_out and out_tlast are stable.

## Test plan
- IMG_WIDTH=4, 4x4 frame with pixel = 4*row+col, i_busy=0 → exactly 4 windows.
  - The first window follows pixel 10 and holds rows {0,1,2 | 4,5,6 | 8,9,10}.
  - The last window holds {5,6,7 | 9,10,11 | 13,14,15} with out_tlast=1.
- Same frame, i_busy high for 5 cycles while first window is pending → o_busy=1, packed_out stable, no pixel accepted. The remaining windows arrive in order after release, with no loss or duplication.
- Back-to-back frames, with the second frame's pixels = first + 100 → second frame's first window is {100,101,102 | 104,105,106 | 108,109,110}. Frame-1 data never leaks into frame 2.
- Truncated frame: in_tlast on row 2 col 1 → no window and no out_tlast. The next full frame produces the normal 4 windows.
- ARESETN pulsed low after pixel 9 → outputs go to reset values immediately and o_busy=1. A fresh 4x4 frame afterwards produces the correct 4 windows.
- Random i_pix_strobe and i_busy, 100 random 4x6 frames → windows match the scoreboard model, and out_tlast is seen exactly once per frame.
